// File: rtl/sevseg_pkg.sv
// Shared constants, types and helpers for the 8-digit seven-segment scan path.
package sevseg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int NUM_SRC    = 3;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int SRC_W      = $clog2(NUM_SRC);
    localparam int SNAP_W     = NUM_DIGITS * DIGIT_W;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    // Active-low anodes: exactly the selected digit is pulled low.
    function automatic logic [NUM_DIGITS-1:0] anode_onecold(input logic [IDX_W-1:0] idx);
        anode_onecold = ~(NUM_DIGITS'(1) << idx);
    endfunction

    // Index of the lowest set bit, i.e. the highest-priority requester.
    function automatic logic [SRC_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        lowest_set = '0;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (v[s]) lowest_set = SRC_W'(s);
        end
    endfunction

endpackage

// File: rtl/sevseg_scan_arbiter_if.sv
// Client-facing bundle of the scan arbiter: request/grant, source data and display outputs.
interface sevseg_scan_arbiter_if;
    import sevseg_pkg::*;

    // src_req is a level: a source holds it for as long as it wants the display and
    // drops it to release. src_gnt is one-hot (or 0 when idle) and only changes at a
    // frame end, so a source may treat its grant bit as stable for a whole frame.
    logic [NUM_SRC-1:0]            src_req;
    logic [NUM_SRC*SNAP_W-1:0]     src_data;
    logic [NUM_SRC*NUM_DIGITS-1:0] src_blank;
    logic [NUM_SRC-1:0]            src_gnt;
    logic [NUM_DIGITS-1:0]         an;
    logic [DIGIT_W-1:0]            digit;
    logic                          frame_tick;
    logic [SRC_W-1:0]              active_src;
    state_e                        dbg_state;

    modport master (
        output src_req, src_data, src_blank,
        input  src_gnt, an, digit, frame_tick, active_src, dbg_state
    );

    modport slave (
        input  src_req, src_data, src_blank,
        output src_gnt, an, digit, frame_tick, active_src, dbg_state
    );

endinterface

// File: rtl/sevseg_scan_timer.sv
// Free-running digit scan timer: prescaler plus digit index, with step and frame-end strobes.
module sevseg_scan_timer
    import sevseg_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             step_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_end_o
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign step_o      = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_end_o = step_o && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign idx_o       = idx_q;

    // NUM_DIGITS is a power of two, so the index wraps 7->0 by natural overflow.
    always_comb begin
        presc_d = step_o ? '0 : presc_q + PW'(1);
        idx_d   = step_o ? idx_q + IDX_W'(1) : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/sevseg_scan_arbiter.sv
// Seven-segment scan controller: fixed-priority arbiter with minimum hold, per-frame
// snapshot of the owner's digits and blank mask, and registered anode/digit drive.
module sevseg_scan_arbiter
    import sevseg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 4
) (
    input logic                  clk,
    input logic                  rst,
    sevseg_scan_arbiter_if.slave bus
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic             step;
    logic             frame_end;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;

    state_e                state_q, state_d;
    logic [SRC_W-1:0]      owner_q, owner_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [SNAP_W-1:0]     data_q, data_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic [NUM_SRC-1:0]    gnt_q, gnt_d;

    logic [NUM_SRC-1:0] own_mask;
    logic [NUM_SRC-1:0] others;
    logic [NUM_SRC-1:0] higher;

    sevseg_scan_timer #(
        .SCAN_DIV(SCAN_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .step_o     (step),
        .idx_o      (idx),
        .frame_end_o(frame_end)
    );

    assign idx_nx   = idx + IDX_W'(1);
    assign own_mask = NUM_SRC'(1) << owner_q;
    assign others   = bus.src_req & ~own_mask;
    assign higher   = bus.src_req & (own_mask - NUM_SRC'(1));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        data_d  = data_q;
        blank_d = blank_q;
        an_d    = an_q;
        digit_d = digit_q;
        gnt_d   = gnt_q;

        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (|bus.src_req) begin
                        state_d = OWNED;
                        owner_d = lowest_set(bus.src_req);
                        hold_d  = '0;
                    end
                end
                OWNED: begin
                    if (!bus.src_req[owner_q]) begin
                        hold_d = '0;
                        if (|others) begin
                            owner_d = lowest_set(others);
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (hold_q < HW'(HOLD_FRAMES)) begin
                        hold_d = hold_q + HW'(1);
                    end else if (|higher) begin
                        owner_d = lowest_set(higher);
                        hold_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Capture the incoming owner's frame so mid-frame source edits stay hidden.
            for (int s = 0; s < NUM_SRC; s++) begin
                if (owner_d == SRC_W'(s)) begin
                    data_d  = bus.src_data[s*SNAP_W +: SNAP_W];
                    blank_d = bus.src_blank[s*NUM_DIGITS +: NUM_DIGITS];
                end
            end
            gnt_d = (state_d == OWNED) ? (NUM_SRC'(1) << owner_d) : '0;
        end

        // Outputs are computed for the digit about to be lit, so they land on the
        // same edge as the index change (and as the grant change on a handover).
        if (step) begin
            if (state_d == OWNED) begin
                an_d    = anode_onecold(idx_nx) | {NUM_DIGITS{blank_d[idx_nx]}};
                digit_d = data_d[{idx_nx, 2'b00} +: DIGIT_W];
            end else begin
                an_d    = ANODE_OFF;
                digit_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            blank_q <= '0;
            an_q    <= ANODE_OFF;
            digit_q <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            digit_q <= digit_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.src_gnt    = gnt_q;
    assign bus.an         = an_q;
    assign bus.digit      = digit_q;
    assign bus.frame_tick = frame_end;
    assign bus.active_src = owner_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/sevseg_scan_arbiter.md
# sevseg_scan_arbiter

Time-multiplexing scan controller and requester arbiter for the 8-digit common-anode seven-segment display. Three display clients request the display; the block grants one at a time with fixed priority and a minimum hold time. It snapshots the owner's 32-bit nibble data and blank mask once per frame. It then drives the one-cold anode pattern and the current 4-bit digit value to the segment decoder.

## Interface
- SCAN_DIV, 50000: clk cycles each digit is lit; must be ≥ 2.
- HOLD_FRAMES, 4: minimum frames an owner keeps the display before preemption; must be ≥ 1.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- src_req  in  3  request per source; bit 0 has the highest priority
- src_data  in  96  source s nibbles at [32s+31:32s]; digit d is at bits [4d+3:4d]
- src_blank  in  24  source s blank mask at [8s+7:8s]; bit d=1 keeps digit d dark
- src_gnt  out  3  one-hot grant, or 0 when idle
- an  out  8  anode enables, active-low, one-cold; 8'hFF means dark
- digit  out  4  nibble for the currently lit digit
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame
- active_src  out  2  index of the current owner; meaningful only while src_gnt≠0

## Operation
- Scan timer:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. Its terminal count is `step`.
  - Digit index idx counts 0..7. It increments on `step` and wraps 7→0.
  - Frame end = `step` && idx==7. frame_tick is asserted combinationally on that cycle.
  - The timer runs continuously, whether or not the display is owned.
- Arbiter states:
  - IDLE: src_gnt=0, an=8'hFF.
  - OWNED: src_gnt one-hot.
  - Decisions are made only at frame end.
- From IDLE: if any src_req is set, grant the lowest-index requester, clear hold_cnt and go to OWNED. Otherwise stay in IDLE.
- From OWNED, owner o:
  - If src_req[o]=0: grant the lowest-index other requester, or return to IDLE if there is none.
  - Else if hold_cnt < HOLD_FRAMES: keep o and increment hold_cnt.
  - Else if a requester with index < o exists: grant the lowest such requester and clear hold_cnt.
  - Otherwise keep o; hold_cnt saturates.
- A lower-priority requester never preempts an owner that is still requesting.
- Re-granting the same owner does not clear hold_cnt.
- Snapshot: at every frame end, the next owner's src_data and src_blank are copied into frame registers. Source data changes mid-frame are invisible until the next frame.
- Display output:
  - While OWNED: an = ~(1<<idx) | {8{blank_snap[idx]}}, and digit = data_snap[4·idx+3:4·idx].
  - While IDLE: an=8'hFF and digit=0.
- hold_cnt width is $clog2(HOLD_FRAMES+1). Prescaler width is $clog2(SCAN_DIV).

## Timing
- Reset values:
  - an=8'hFF, digit=0, src_gnt=0, active_src=0, frame_tick=0.
  - prescaler=0, idx=0, state IDLE, hold_cnt=0, snapshots 0.
- Reset mid-frame takes effect on the next clk edge. There is no partial-frame residue.
- an, digit, src_gnt and active_src are registered:
  - They update on the edge after the `step` or frame-end cycle that caused the change.
  - On a handover, the new owner's digit 0 appears on the same edge that src_gnt changes.
- Frame length is 8·SCAN_DIV cycles.
- Request-to-grant latency is at most 8·SCAN_DIV cycles, plus HOLD_FRAMES frames if another source holds the display.
- A src_req change sampled on the frame-end cycle itself is honoured at that frame end.
- src_req is level-sensitive. A source drops req to release; release takes effect at the next frame end.

## Structure
- Shared package sevseg_pkg:
  - NUM_DIGITS=8, DIGIT_W=4, NUM_SRC=3.
  - ANODE_OFF=8'hFF.
  - State enum {IDLE, OWNED}.
  - Function anode_onecold(idx).
- Sub-module sevseg_scan_timer: the prescaler plus digit index. It outputs step, idx and frame_end.
- Arbitration, snapshot and output registers live in the top module.

## Test plan
All scenarios use SCAN_DIV=4 and HOLD_FRAMES=2, so one frame is 32 cycles.
- **Reset:** assert rst for 3 cycles at an arbitrary point mid-frame → an=FF, digit=0, src_gnt=0 on the following edge; first frame_tick appears 32 cycles after rst is released.
- **Single requester:** src_req=3'b010, src_data[63:32]=32'h87654321, blank 0 → src_gnt=010 after the first frame end; an cycles FE,FD,FB,F7,EF,DF,BF,7F for 4 cycles each, with digit 1,2,…,8.
- **Blanking:** same as the single-requester case, with blank mask 8'hF0 → an=FF during idx 4–7; digits 0–3 display normally.
- **Preemption with hold:** src2 owns; src0 asserts req in src2's first frame → src2 keeps the display for exactly 2 more frame ends; src_gnt becomes 001 at the third frame end after src2's grant.
- **Mid-frame data change:** change the owner's data from 32'h11111111 to 32'h22222222 at idx=3 → digits stay 1 until the frame end, then show 2 from idx 0.
- **Release:** the owner drops src_req with no other requesters → IDLE at the next frame end; an=FF and src_gnt=0 from the following edge.
